counter_8bit: RTL

Synchronous up-counter with overwrite, the first stateful stage after the gate-level cells. Its count enable is driven directly by the two-input OR gate cell, so either of two increment requests advances the count. It produces the running count and a one-cycle wrap pulse for downstream program-counter and timing stages. The counter register is built from the shared 1-bit storage cell.

---
 rtl/counter_8bit_pkg.sv | 32 +++
 rtl/counter_8bit_if.sv | 20 ++
 rtl/counter_8bit_bit_register.sv | 23 ++
 rtl/counter_8bit_full_adder.sv | 11 +
 rtl/counter_8bit.sv | 86 ++++++++
 5 files changed

// File: rtl/counter_8bit_pkg.sv
// Shared constants and types for the 8-bit up-counter and downstream program-counter stages.
package counter_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_STEP  = 1;

    // Count-type alias consumed by downstream PC stages
    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    // Source selected for the next register value, highest priority first
    typedef enum logic [1:0] {
        SEL_RST  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_STEP = 2'd2,
        SEL_HOLD = 2'd3
    } next_sel_e;

    function automatic next_sel_e pick_sel(input logic rst, input logic load, input logic en);
        next_sel_e sel;
        if (rst) begin
            sel = SEL_RST;
        end else if (load) begin
            sel = SEL_LOAD;
        end else if (en) begin
            sel = SEL_STEP;
        end else begin
            sel = SEL_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/counter_8bit_if.sv
// Request/result bundle between the counter and its upstream/downstream stages.
interface counter_8bit_if import counter_8bit_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_load;
    logic [WIDTH-1:0] in_data;
    logic             in_en;
    logic [WIDTH-1:0] out;
    logic             out_wrap;

    modport master (
        output in_load, in_data, in_en,
        input  out, out_wrap
    );

    modport slave (
        input  in_load, in_data, in_en,
        output out, out_wrap
    );
endinterface

// File: rtl/counter_8bit_bit_register.sv
// Shared 1-bit storage cell: synchronous active-high reset to 0, save-enable.
module bit_register (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    logic q_r;

    // Storage flop: reset dominates, otherwise capture d when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/counter_8bit_full_adder.sv
// Single-bit full-adder cell; chained ripple-carry to form the step adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/counter_8bit.sv
// Up-counter with overwrite: priority rst > load > step > hold, carry-out of the step drives a one-cycle wrap pulse.
module counter_8bit import counter_8bit_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic           clk,
    input  logic           rst,
    counter_8bit_if.slave  bus
);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] next_count_s;
    logic             next_wrap_s;
    logic             wrap_s;
    logic             count_en_s;
    next_sel_e        sel_s;

    assign carry_s[0] = 1'b0;

    // Ripple-carry adder; carry_s[WIDTH] is bit WIDTH of the WIDTH+1-bit sum
    for (genvar i = 0; i < WIDTH; i++) begin : g_adder
        full_adder u_fa (
            .a    (count_s[i]),
            .b    (STEP_V[i]),
            .cin  (carry_s[i]),
            .sum  (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // Next-value mux for the count and wrap registers
    always_comb begin
        sel_s        = pick_sel(rst, bus.in_load, bus.in_en);
        next_count_s = count_s;
        next_wrap_s  = 1'b0;
        count_en_s   = 1'b1;
        case (sel_s)
            SEL_RST: begin
                next_count_s = {WIDTH{1'b0}};
                next_wrap_s  = 1'b0;
            end
            SEL_LOAD: begin
                next_count_s = bus.in_data;
                next_wrap_s  = 1'b0;
            end
            SEL_STEP: begin
                next_count_s = sum_s;
                next_wrap_s  = carry_s[WIDTH];
            end
            SEL_HOLD: begin
                next_count_s = count_s;
                next_wrap_s  = 1'b0;
                count_en_s   = 1'b0;
            end
            default: begin
                next_count_s = {WIDTH{1'b0}};
                next_wrap_s  = 1'b0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_count
        bit_register u_bit (
            .clk (clk),
            .rst (rst),
            .en  (count_en_s),
            .d   (next_count_s[i]),
            .q   (count_s[i])
        );
    end

    // Wrap flag reloads every cycle so the pulse lasts exactly one cycle
    bit_register u_wrap (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (next_wrap_s),
        .q   (wrap_s)
    );

    assign bus.out      = count_s;
    assign bus.out_wrap = wrap_s;
endmodule
